// File: rtl/tdest_demux_if.sv
// AXI-Stream bundle for the tdest demux. NUM_CH sets the width of the
// valid/ready pair, so one interface type serves both the slave and the fanned-out master.
interface tdest_demux_if #(
    parameter int TDATA_WIDTH = 64,
    parameter int TDEST_WIDTH = 4,
    parameter int NUM_CH      = 1
);
    logic [NUM_CH-1:0]        tvalid;
    logic [NUM_CH-1:0]        tready;
    logic [TDATA_WIDTH-1:0]   tdata;
    logic [TDATA_WIDTH/8-1:0] tkeep;
    logic                     tlast;
    logic                     tuser;
    logic [TDEST_WIDTH-1:0]   tdest;

    modport master (output tvalid, tdata, tkeep, tlast, tuser, tdest, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tuser, tdest, output tready);
endinterface

// File: rtl/tdest_demux.sv
// Routes each tdest-tagged packet to one of NUM_PORTS outputs through a single
// registered beat slice; packets with an out-of-range tdest are drained and counted.
module tdest_demux #(
    parameter int TDEST_WIDTH = 4,
    parameter int TDATA_WIDTH = 64,
    parameter int NUM_PORTS   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    tdest_demux_if.slave         s_axis,
    tdest_demux_if.master        m_axis,
    output logic [15:0]          drop_count,
    output logic [31:0]          fwd_count
);
    localparam int KW = TDATA_WIDTH / 8;
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [TDEST_WIDTH:0] NP = (TDEST_WIDTH + 1)'(NUM_PORTS);

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    typedef struct packed {
        logic [TDATA_WIDTH-1:0] data;
        logic [KW-1:0]          keep;
        logic                   last;
        logic                   user;
    } beat_t;

    state_t        state, state_nxt;
    logic [PW-1:0] sel, out_port, tgt;
    logic          out_valid;
    beat_t         out_beat;
    logic          first, in_range, dropping, hs, load;

    assign first    = (state == IDLE);
    // One extra bit so NUM_PORTS == 2**TDEST_WIDTH compares correctly.
    assign in_range = {1'b0, s_axis.tdest} < NP;
    assign dropping = (state == DROP) || (first && !in_range);
    assign tgt      = first ? s_axis.tdest[PW-1:0] : sel;

    assign s_axis.tready = dropping || !out_valid || m_axis.tready[out_port];
    assign hs            = s_axis.tvalid && s_axis.tready;
    assign load          = hs && !dropping;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (hs) begin
            case (state)
                IDLE:    if (!s_axis.tlast) state_nxt = in_range ? FWD : DROP;
                default: if (s_axis.tlast)  state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel        <= '0;
            out_port   <= '0;
            out_valid  <= 1'b0;
            out_beat   <= '0;
            drop_count <= '0;
            fwd_count  <= '0;
        end else begin
            if (hs && first && in_range) begin
                sel       <= tgt;
                fwd_count <= fwd_count + 32'd1;
            end
            if (hs && first && !in_range && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
            // A new beat may replace the held one on the cycle it is accepted.
            if (load) begin
                out_beat  <= {s_axis.tdata, s_axis.tkeep, s_axis.tlast, s_axis.tuser};
                out_port  <= tgt;
                out_valid <= 1'b1;
            end else if (out_valid && m_axis.tready[out_port]) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign m_axis.tdata = out_beat.data;
    assign m_axis.tkeep = out_beat.keep;
    assign m_axis.tlast = out_beat.last;
    assign m_axis.tuser = out_beat.user;
    assign m_axis.tdest = TDEST_WIDTH'(out_port);

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_vld
        assign m_axis.tvalid[i] = out_valid && (out_port == PW'(i));
    end
endmodule
